// File: rtl/sca_writeback.sv
// Scalar write-back queue: merges ALU and load results into one ordered register-bank
// write per cycle and reports to decode whether a register still has a write queued.
module sca_writeback #(
   parameter int DEPTH = 4,
   parameter int DW    = 8,
   parameter int AW    = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [AW-1:0]            alu_dir,
   input  logic [DW-1:0]            alu_data,
   input  logic                     mem_valid,
   input  logic [AW-1:0]            mem_dir,
   input  logic [DW-1:0]            mem_data,
   output logic                     stall,
   input  logic [AW-1:0]            chk_dir,
   output logic                     chk_pending,
   output logic                     reg_wr,
   output logic [AW-1:0]            dir_wrs,
   output logic [DW-1:0]            data_wr,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] dir_mem_r  [DEPTH];
   logic [DW-1:0] data_mem_r [DEPTH];
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;
   logic          reg_wr_r;
   logic [AW-1:0] dir_wrs_r;
   logic [DW-1:0] data_wr_r;
   logic          ovf_r;

   logic          pop_s;
   logic [CW:0]   free_s;
   logic          mem_acc_s;
   logic          alu_acc_s;
   logic          drop_s;
   logic [PW-1:0] alu_slot_s;
   logic [CW-1:0] count_next_s;
   logic          pending_s;

   // Admission: free slots include the one released by this edge's pop; mem is served before ALU.
   always_comb begin
      pop_s  = (count_r != {CW{1'b0}});
      free_s = (CW+1)'(DEPTH) - {1'b0, count_r} + {{CW{1'b0}}, pop_s};
      if (mem_valid && (free_s != {(CW+1){1'b0}})) begin
         mem_acc_s = 1'b1;
      end else begin
         mem_acc_s = 1'b0;
      end
      if (alu_valid && (free_s > {{CW{1'b0}}, mem_acc_s})) begin
         alu_acc_s = 1'b1;
      end else begin
         alu_acc_s = 1'b0;
      end
      drop_s       = (mem_valid & ~mem_acc_s) | (alu_valid & ~alu_acc_s);
      alu_slot_s   = wr_ptr_r + PW'(mem_acc_s);
      count_next_s = count_r + CW'(mem_acc_s) + CW'(alu_acc_s) - CW'(pop_s);
   end

   // Entry storage; contents past the occupancy are never observed, so no reset is needed.
   always_ff @(posedge clk) begin
      if (mem_acc_s) begin
         dir_mem_r[wr_ptr_r]  <= mem_dir;
         data_mem_r[wr_ptr_r] <= mem_data;
      end
      if (alu_acc_s) begin
         dir_mem_r[alu_slot_s]  <= alu_dir;
         data_mem_r[alu_slot_s] <= alu_data;
      end
   end

   // Pointers, occupancy, registered bank write port and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_r  <= {PW{1'b0}};
         wr_ptr_r  <= {PW{1'b0}};
         count_r   <= {CW{1'b0}};
         reg_wr_r  <= 1'b0;
         dir_wrs_r <= {AW{1'b0}};
         data_wr_r <= {DW{1'b0}};
         ovf_r     <= 1'b0;
      end else begin
         rd_ptr_r <= rd_ptr_r + PW'(pop_s);
         wr_ptr_r <= wr_ptr_r + PW'(mem_acc_s) + PW'(alu_acc_s);
         count_r  <= count_next_s;
         if (pop_s) begin
            reg_wr_r  <= 1'b1;
            dir_wrs_r <= dir_mem_r[rd_ptr_r];
            data_wr_r <= data_mem_r[rd_ptr_r];
         end else begin
            reg_wr_r  <= 1'b0;
         end
         if (drop_s) begin
            ovf_r <= 1'b1;
         end
      end
   end

   // Pending lookup over occupied entries only; the issued entry has already left the queue.
   always_comb begin
      pending_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < count_r) && (dir_mem_r[rd_ptr_r + PW'(i)] == chk_dir)) begin
            pending_s = 1'b1;
         end else begin
            pending_s = pending_s;
         end
      end
   end

   assign stall       = (count_r > CW'(DEPTH - 2));
   assign chk_pending = pending_s;
   assign count       = count_r;
   assign reg_wr      = reg_wr_r;
   assign dir_wrs     = dir_wrs_r;
   assign data_wr     = data_wr_r;
   assign ovf         = ovf_r;

endmodule

// File: tb/tb_sca_writeback.sv
// Bench for sca_writeback: directed scenarios plus random traffic against a queue-based model.
module tb_sca_writeback;
   localparam int DEPTH = 4;
   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid, mem_valid;
   logic [AW-1:0] alu_dir, mem_dir, chk_dir;
   logic [DW-1:0] alu_data, mem_data;
   logic          stall, chk_pending, reg_wr, ovf;
   logic [AW-1:0] dir_wrs;
   logic [DW-1:0] data_wr;
   logic [CW-1:0] count;

   sca_writeback #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_dir(alu_dir), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_dir(mem_dir), .mem_data(mem_data),
      .stall(stall), .chk_dir(chk_dir), .chk_pending(chk_pending),
      .reg_wr(reg_wr), .dir_wrs(dir_wrs), .data_wr(data_wr),
      .count(count), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] dir;
      logic [DW-1:0] data;
   } ent_t;

   ent_t          q[$];
   logic          m_reg_wr;
   logic [AW-1:0] m_dir;
   logic [DW-1:0] m_data;
   logic          m_ovf;
   int            n_cmp = 0;
   int            n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic m_pending(input logic [AW-1:0] d);
      foreach (q[i]) if (q[i].dir == d) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      q.delete();
      m_reg_wr = 1'b0;
      m_dir    = '0;
      m_data   = '0;
      m_ovf    = 1'b0;
   endtask

   task automatic check_all();
      check("count",   32'(count),   32'(q.size()));
      check("stall",   32'(stall),   32'(q.size() > DEPTH - 2));
      check("pending", 32'(chk_pending), 32'(m_pending(chk_dir)));
      check("reg_wr",  32'(reg_wr),  32'(m_reg_wr));
      check("dir_wrs", 32'(dir_wrs), 32'(m_dir));
      check("data_wr", 32'(data_wr), 32'(m_data));
      check("ovf",     32'(ovf),     32'(m_ovf));
   endtask

   // One rising edge: head leaves first, then mem and ALU take whatever room is left.
   task automatic model_edge();
      if (q.size() > 0) begin
         m_reg_wr = 1'b1;
         m_dir    = q[0].dir;
         m_data   = q[0].data;
         void'(q.pop_front());
      end else begin
         m_reg_wr = 1'b0;
      end
      if (mem_valid) begin
         if (q.size() < DEPTH) q.push_back({mem_dir, mem_data});
         else m_ovf = 1'b1;
      end
      if (alu_valid) begin
         if (q.size() < DEPTH) q.push_back({alu_dir, alu_data});
         else m_ovf = 1'b1;
      end
   endtask

   task automatic step(input logic mv, input logic [AW-1:0] md, input logic [DW-1:0] mdd,
                       input logic av, input logic [AW-1:0] ad, input logic [DW-1:0] add,
                       input logic [AW-1:0] ck);
      mem_valid = mv; mem_dir = md; mem_data = mdd;
      alu_valid = av; alu_dir = ad; alu_data = add;
      chk_dir   = ck;
      #1;
      check_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'(i));
   endtask

   initial begin
      rst = 1'b1;
      mem_valid = 1'b0; mem_dir = '0; mem_data = '0;
      alu_valid = 1'b0; alu_dir = '0; alu_data = '0;
      chk_dir = '0;
      model_reset();
      #12;
      @(negedge clk);
      check_all();
      rst = 1'b0;

      // single ALU write
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h5A, 3'd2);
      step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd2);
      #1;
      check("t1_reg_wr",  32'(reg_wr),  32'd1);
      check("t1_dir",     32'(dir_wrs), 32'd2);
      check("t1_data",    32'(data_wr), 32'h5A);
      check("t1_pending", 32'(chk_pending), 32'd0);
      idle(2);

      // dual push to the same register
      step(1'b1, 3'd3, 8'h11, 1'b1, 3'd3, 8'h22, 3'd3);
      idle(3);
      check("t2_last", 32'(data_wr), 32'h22);

      // fill past capacity, ignoring stall
      for (int i = 0; i < 4; i++)
         step(1'b1, 3'(i), 8'hA0 + 8'(i), 1'b1, 3'(i + 4), 8'hB0 + 8'(i), 3'(i));
      idle(6);
      check("t3_ovf", 32'(ovf), 32'd1);

      // reset mid-operation with count=3 and reg_wr=1
      step(1'b1, 3'd1, 8'hC1, 1'b1, 3'd2, 8'hC2, 3'd1);
      step(1'b1, 3'd3, 8'hC3, 1'b1, 3'd4, 8'hC4, 3'd4);
      #1;
      check("t4_pre_count", 32'(count),  32'd3);
      check("t4_pre_wr",    32'(reg_wr), 32'd1);
      mem_valid = 1'b0; alu_valid = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(3);

      // steady single push, then pointer wrap
      for (int i = 0; i < 10; i++)
         step(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 8'h30 + 8'(i), 3'(i));
      idle(2);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 3'(7 - i), 8'h60 + 8'(i), 1'b0, 3'd0, 8'h00, 3'(7 - i));
         step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'(i));
      end
      check("t6_ovf", 32'(ovf), 32'd0);

      // random traffic, mostly honouring stall
      for (int i = 0; i < 400; i++) begin
         logic go;
         go = (q.size() <= DEPTH - 2) || ($urandom_range(0, 15) == 0);
         step(go & 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
              go & 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
              3'($urandom_range(0, 7)));
      end
      idle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
